// File: rtl/ws2812_frame_scheduler.sv
// Frame scheduler: picks A or B on each refresh tick, scales the chosen colour, builds a packed frame into a shadow buffer and hands it to the ws2812 driver.
// Latency: grant to commit takes NUM_LEDS+2 cycles minimum (1 scale cycle, NUM_LEDS build cycles, then a commit edge).
// Backpressure: the commit waits in WAIT while drv_idle is low; ticks that arrive meanwhile coalesce into one pending request, and overrun records any that were dropped.
module ws2812_frame_scheduler #(
  parameter int NUM_LEDS       = 16,
  parameter int REFRESH_CYCLES = 240000,
  parameter int MAX_SKIP       = 3
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  req_a,
  input  logic [NUM_LEDS-1:0]   bitmap_a,
  input  logic [23:0]           colour_a,
  input  logic                  req_b,
  input  logic [NUM_LEDS-1:0]   bitmap_b,
  input  logic [23:0]           colour_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  input  logic [7:0]            brightness,
  input  logic                  drv_idle,
  output logic [24*NUM_LEDS-1:0] frame_out,
  output logic                  commit,
  output logic                  overrun
);

  localparam int CNT_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IDX_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int SKIP_W = (MAX_SKIP > 0) ? $clog2(MAX_SKIP + 1) : 1;

  typedef enum logic [1:0] {IDLE, SCALE, BUILD, WAIT} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        tick_cnt;
  logic                    tick;
  logic                    pending;
  logic [SKIP_W-1:0]       skip;
  logic [NUM_LEDS-1:0]     cap_bitmap;
  logic [23:0]             cap_colour;
  logic [23:0]             scaled;
  logic [IDX_W-1:0]        idx;
  logic [24*NUM_LEDS-1:0]  shadow;
  logic                    any_req;
  logic                    a_wins;

  assign tick    = (tick_cnt == '0);
  assign any_req = req_a | req_b;
  // B has priority, except that A is forced once it has been passed over MAX_SKIP times in a row
  assign a_wins  = req_a & (~req_b | (skip == SKIP_W'(MAX_SKIP)));

  // (c * (brightness+1)) >> 8 on a 17-bit product; 255 leaves c unchanged, 0 blanks it
  function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] br);
    logic [16:0] prod;
    prod = {9'd0, c} * {8'd0, ({1'b0, br} + 9'd1)};
    return prod[15:8];
  endfunction

  // Refresh divider: count down from REFRESH_CYCLES-1 and reload on reaching zero
  always_ff @(posedge CLK) begin
    if (!RESET_N)
      tick_cnt <= CNT_W'(REFRESH_CYCLES - 1);
    else if (tick)
      tick_cnt <= CNT_W'(REFRESH_CYCLES - 1);
    else
      tick_cnt <= tick_cnt - CNT_W'(1);
  end

  // Pending tick latch: IDLE consumes it (granted or not), a fresh tick wins, a tick on top of one still pending sets overrun
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (tick)
        pending <= 1'b1;
      else if (state == IDLE && pending)
        pending <= 1'b0;
      if (tick && pending)
        overrun <= 1'b1;
    end
  end

  // Main sequencer: arbitrate, scale, build shadow one LED per cycle, commit while the driver is idle
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= IDLE;
      frame_out <= '0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      commit    <= 1'b0;
      skip      <= '0;
      idx       <= '0;
    end else begin
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      commit <= 1'b0;
      case (state)
        IDLE: begin
          if (pending && any_req) begin
            if (a_wins) begin
              gnt_a      <= 1'b1;
              cap_bitmap <= bitmap_a;
              cap_colour <= colour_a;
              skip       <= '0;
            end else begin
              gnt_b      <= 1'b1;
              cap_bitmap <= bitmap_b;
              cap_colour <= colour_b;
              skip       <= req_a ? skip + SKIP_W'(1) : '0;
            end
            state <= SCALE;
          end
        end
        SCALE: begin
          scaled <= {scale_byte(cap_colour[23:16], brightness),
                     scale_byte(cap_colour[15:8],  brightness),
                     scale_byte(cap_colour[7:0],   brightness)};
          idx    <= '0;
          state  <= BUILD;
        end
        BUILD: begin
          shadow[24*idx +: 24] <= cap_bitmap[idx] ? scaled : 24'h0;
          if (idx == IDX_W'(NUM_LEDS - 1))
            state <= WAIT;
          else
            idx <= idx + IDX_W'(1);
        end
        WAIT: begin
          if (drv_idle) begin
            frame_out <= shadow;
            commit    <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Bench for ws2812_frame_scheduler: a timestamp-level reference model predicts every output each cycle,
// and directed phases add hand-computed checks on latency, scaled colours, grant order and overrun.
// Inputs change on the falling edge; the model updates on the rising edge and outputs are compared on the falling edge.
module tb_ws2812_frame_scheduler;

  localparam int N  = 16;
  localparam int R  = 64;
  localparam int MS = 3;
  localparam int FW = 24 * N;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          req_a, req_b;
  logic [N-1:0]  bitmap_a, bitmap_b;
  logic [23:0]   colour_a, colour_b;
  logic          gnt_a, gnt_b;
  logic [7:0]    brightness;
  logic          drv_idle;
  logic [FW-1:0] frame_out;
  logic          commit;
  logic          overrun;

  always #5 CLK = ~CLK;

  ws2812_frame_scheduler #(.NUM_LEDS(N), .REFRESH_CYCLES(R), .MAX_SKIP(MS)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_a(req_a), .bitmap_a(bitmap_a), .colour_a(colour_a),
    .req_b(req_b), .bitmap_b(bitmap_b), .colour_b(colour_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .brightness(brightness), .drv_idle(drv_idle),
    .frame_out(frame_out), .commit(commit), .overrun(overrun)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Ticks fall on rising edges whose post-reset index is a multiple of R; a frame granted at
  // edge G samples brightness at G+1 and may commit at the first edge >= G+N+2 with drv_idle high.
  bit            m_on = 1'b0;
  int            cyc;
  bit            m_pend, m_busy, p_old, was_idle, a_win;
  int            m_gedge, m_skip;
  logic [N-1:0]  m_bm;
  logic [23:0]   m_col;
  logic [FW-1:0] m_inflight, e_frame;
  logic          e_ga, e_gb, e_cm, e_ov;

  function automatic logic [7:0] sc(input logic [7:0] c, input logic [7:0] br);
    int v;
    v = (int'(c) * (int'(br) + 1)) / 256;
    return 8'(v);
  endfunction

  function automatic logic [FW-1:0] frame_of(input logic [N-1:0] bm, input logic [23:0] col,
                                             input logic [7:0] br);
    logic [FW-1:0] f;
    logic [23:0]   led;
    f   = '0;
    led = {sc(col[23:16], br), sc(col[15:8], br), sc(col[7:0], br)};
    for (int i = 0; i < N; i++)
      if (bm[i]) f[24*i +: 24] = led;
    return f;
  endfunction

  always @(posedge CLK) begin
    if (RESET_N === 1'b0) begin
      m_on = 1'b1; cyc = 0; m_pend = 1'b0; m_busy = 1'b0; m_skip = 0;
      e_frame = '0; e_ga = 1'b0; e_gb = 1'b0; e_cm = 1'b0; e_ov = 1'b0;
    end else if (m_on) begin
      cyc++;
      e_ga = 1'b0; e_gb = 1'b0; e_cm = 1'b0;
      p_old    = m_pend;
      was_idle = !m_busy;
      if (m_busy && cyc == m_gedge + 1)
        m_inflight = frame_of(m_bm, m_col, brightness);
      if (m_busy && cyc >= m_gedge + N + 2 && drv_idle) begin
        e_frame = m_inflight;
        e_cm    = 1'b1;
        m_busy  = 1'b0;
      end
      if (was_idle && p_old) begin
        m_pend = 1'b0;
        if (req_a || req_b) begin
          a_win = req_a && (!req_b || m_skip == MS);
          if (a_win) begin
            e_ga = 1'b1; m_bm = bitmap_a; m_col = colour_a; m_skip = 0;
          end else begin
            e_gb = 1'b1; m_bm = bitmap_b; m_col = colour_b;
            m_skip = req_a ? m_skip + 1 : 0;
          end
          m_busy  = 1'b1;
          m_gedge = cyc;
        end
      end
      if (cyc % R == 0) begin
        if (p_old) e_ov = 1'b1;
        m_pend = 1'b1;
      end
    end
  end

  // Compare every output against the model on every falling edge once reset has been seen
  always @(negedge CLK) begin
    if (m_on) begin
      check("gnt_a", {{(FW-1){1'b0}}, gnt_a}, {{(FW-1){1'b0}}, e_ga});
      check("gnt_b", {{(FW-1){1'b0}}, gnt_b}, {{(FW-1){1'b0}}, e_gb});
      check("commit", {{(FW-1){1'b0}}, commit}, {{(FW-1){1'b0}}, e_cm});
      check("overrun", {{(FW-1){1'b0}}, overrun}, {{(FW-1){1'b0}}, e_ov});
      check("frame_out", frame_out, e_frame);
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic sig(input int w);
    case (w)
      0:       return gnt_a;
      1:       return gnt_b;
      2:       return commit;
      default: return gnt_a | gnt_b;
    endcase
  endfunction

  task automatic wait_for(input string name, input int w, input int limit, output int n);
    n = 0;
    repeat (limit) begin
      @(negedge CLK);
      n++;
      if (sig(w)) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL %s: no event within %0d cycles, required one", name, limit);
    n = -1;
  endtask

  task automatic count_for(input int w, input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge CLK);
      if (sig(w)) n++;
    end
  endtask

  bit exp_b [15] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0};

  initial begin
    int n;
    int cnt;
    RESET_N    = 1'b0;
    req_a      = 1'($urandom);
    req_b      = 1'($urandom);
    bitmap_a   = 16'($urandom);
    bitmap_b   = 16'($urandom);
    colour_a   = 24'($urandom);
    colour_b   = 24'($urandom);
    brightness = 8'($urandom);
    drv_idle   = 1'($urandom);

    // Reset for two edges with arbitrary inputs
    repeat (2) @(negedge CLK);
    check("rst_frame", frame_out, '0);
    check("rst_gnt", {{(FW-2){1'b0}}, gnt_a, gnt_b}, '0);
    check("rst_commit_ovr", {{(FW-2){1'b0}}, commit, overrun}, '0);

    // Single LED at full brightness, grant-to-commit latency
    RESET_N = 1'b1; req_b = 1'b0; req_a = 1'b1;
    bitmap_a = 16'h0001; colour_a = 24'hFFFFFF; brightness = 8'd255; drv_idle = 1'b1;
    wait_for("t2_gnt", 0, 200, n);
    req_a = 1'b0;
    wait_for("t2_commit", 2, 40, n);
    check("t2_latency", FW'(n), FW'(18));
    check("t2_frame", frame_out, {{(FW-24){1'b0}}, 24'hFFFFFF});
    count_for(3, 80, cnt);
    check("t2_single_gnt", FW'(cnt), '0);

    // Half brightness on every LED, then zero brightness
    bitmap_a = 16'hFFFF; colour_a = 24'h8040FF; brightness = 8'd127; req_a = 1'b1;
    wait_for("t3_gnt", 0, 200, n);
    req_a = 1'b0;
    wait_for("t3_commit", 2, 40, n);
    check("t3_half", frame_out, {N{24'h40207F}});
    brightness = 8'd0; req_a = 1'b1;
    wait_for("t3_gnt0", 0, 200, n);
    req_a = 1'b0;
    wait_for("t3_commit0", 2, 40, n);
    check("t3_zero", frame_out, '0);

    // Fairness: both requesting, then A drops for one tick and returns
    bitmap_a = 16'h00FF; colour_a = 24'h10F020; bitmap_b = 16'hF0F0; colour_b = 24'h123456;
    brightness = 8'd200; req_a = 1'b1; req_b = 1'b1;
    for (int k = 0; k < 15; k++) begin
      wait_for($sformatf("t4_gnt%0d", k), 3, 200, n);
      check($sformatf("t4_order%0d", k), {{(FW-1){1'b0}}, gnt_b}, {{(FW-1){1'b0}}, exp_b[k]});
      if (k == 9)  req_a = 1'b0;
      if (k == 10) req_a = 1'b1;
    end
    req_a = 1'b0; req_b = 1'b0;
    wait_for("t4_commit", 2, 40, n);

    // Driver busy from the end of BUILD: no commit, overrun on the stacked ticks
    req_b = 1'b1; drv_idle = 1'b1;
    wait_for("t5_gnt", 1, 200, n);
    repeat (10) @(negedge CLK);
    drv_idle = 1'b0;
    count_for(2, 150, cnt);
    check("t5_no_commit", FW'(cnt), '0);
    check("t5_overrun", {{(FW-1){1'b0}}, overrun}, FW'(1));
    drv_idle = 1'b1;
    wait_for("t5_commit", 2, 5, n);
    check("t5_commit_lat", FW'(n), FW'(1));
    wait_for("t5_pend_gnt", 1, 5, n);
    check("t5_pend_lat", FW'(n), FW'(1));
    req_b = 1'b0;
    wait_for("t5_commit2", 2, 40, n);

    // Idle ticks with no requester, then reset in the middle of a build
    count_for(3, 140, cnt);
    check("t6_no_gnt", FW'(cnt), '0);
    bitmap_a = 16'hA5A5; colour_a = 24'h00FF00; brightness = 8'd255; req_a = 1'b1;
    wait_for("t6_gnt", 0, 200, n);
    req_a = 1'b0;
    repeat (5) @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    check("t6_rst_frame", frame_out, '0);
    check("t6_rst_overrun", {{(FW-1){1'b0}}, overrun}, '0);
    RESET_N = 1'b1;
    count_for(2, 100, cnt);
    check("t6_no_commit", FW'(cnt), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_scheduler.md
Name: ws2812_frame_scheduler

Overview:
Sits between the frame producers (binary-clock bitmap, set-mode/rainbow overlay) and the ws2812 driver. On each refresh tick it arbitrates between two requesters and applies global brightness scaling. It builds the 16-LED packed frame one LED per cycle into a shadow buffer, then commits it to the driver's packed_rgb_data only while the driver reports idle, so the LED string never receives a torn frame.

Parameters:
NUM_LEDS, 16, number of LEDs in the string (24 bits each)
REFRESH_CYCLES, 240000, CLK cycles between refresh ticks (50 Hz at 12 MHz)
MAX_SKIP, 3, consecutive B wins tolerated while A is waiting before A is forced

Ports:
CLK  in  1  system clock
RESET_N  in  1  synchronous active-low reset
req_a  in  1  requester A (clock display) wants a frame; level
bitmap_a  in  NUM_LEDS  A: LED on/off map, bit i -> LED i
colour_a  in  24  A: colour for lit LEDs
req_b  in  1  requester B (overlay, higher priority); level
bitmap_b  in  NUM_LEDS  B: LED on/off map
colour_b  in  24  B: colour for lit LEDs
gnt_a  out  1  one-cycle pulse, A's inputs captured
gnt_b  out  1  one-cycle pulse, B's inputs captured
brightness  in  8  global scale, 255 = full
drv_idle  in  1  driver between frames, safe to change data
frame_out  out  24*NUM_LEDS  to driver packed_rgb_data, LED i at [24*i +: 24]
commit  out  1  one-cycle pulse, frame_out updated this edge
overrun  out  1  sticky: tick arrived while previous tick still pending

Behaviour:
- Reset (RESET_N low at an edge): state IDLE; frame_out=0; gnt_a=gnt_b=commit=overrun=0; tick counter reloaded to REFRESH_CYCLES-1; pending=0; skip count=0. Reset mid-build or mid-wait abandons the frame; the shadow buffer contents become don't-care.
- Tick counter counts down each cycle. At 0 it reloads and sets pending. If pending is already set, overrun<=1 (sticky until reset). Ticks coalesce into a single pending bit.
- FSM states: IDLE, SCALE, BUILD, WAIT, COMMIT-less. The commit is performed by WAIT.
- IDLE, pending=1:
  - No request: clear pending. No grant; frame_out holds.
  - Request present: arbitrate, pulse the winner's gnt for 1 cycle, capture the winner's bitmap/colour, clear pending, go to SCALE.
- Arbitration:
  - Only one requester: that requester wins.
  - Both requesting: B wins unless skip==MAX_SKIP, in which case A wins.
  - skip increments on a B win with req_a=1. It clears on an A win or when req_a=0 at arbitration.
- SCALE (1 cycle): sample brightness.
  - Each byte c of the captured colour (bits 23:16, 15:8, 7:0, order-agnostic) becomes (c*(brightness+1))>>8.
  - Use a 9x8 product truncated to 8 bits; no rounding.
- BUILD (NUM_LEDS cycles): idx 0..NUM_LEDS-1. shadow[idx] <= bitmap[idx] ? scaled : 24'h0. After idx NUM_LEDS-1, go to WAIT.
- WAIT: on an edge with drv_idle=1: frame_out<=shadow, commit=1 for that cycle, go to IDLE. Hold indefinitely while drv_idle=0.
- Latency: with gnt asserted at edge E0, the earliest frame_out/commit edge is E(NUM_LEDS+2) (E18 for 16 LEDs).
- Input changes after grant have no effect on the frame in flight. Requests are never queued; a requester must hold req until the next tick.
- Ticks during SCALE/BUILD/WAIT set pending and are serviced on return to IDLE.

Test Plan:
1. RESET_N low for 2 edges, with inputs arbitrary -> frame_out=0, gnt_a=gnt_b=commit=overrun=0.
2. REFRESH_CYCLES=64; req_a=1, bitmap_a=16'h0001, colour_a=24'hFFFFFF, brightness=255, drv_idle=1 -> single gnt_a pulse; commit 18 edges later; frame_out[23:0]=24'hFFFFFF and all other LEDs 0.
3. colour_a=24'h8040FF, bitmap_a=16'hFFFF, brightness=127 -> every LED = 24'h40207F. With brightness=0 -> every LED = 0.
4. MAX_SKIP=3; req_a=req_b=1 held for 8 ticks -> grant order B,B,B,A,B,B,B,A. Then drop req_a -> B every tick and skip cleared.
5. drv_idle=0 from end of BUILD for 100 cycles -> no commit and frame_out unchanged. drv_idle=1 -> commit and frame_out update on the next edge.
6. No requests at a tick -> no gnt, frame_out holds. REFRESH_CYCLES=8 with a grant in progress -> overrun=1 and pending tick serviced after commit. RESET_N low mid-BUILD -> IDLE and frame_out=0.
